hough_vote_ctrl: RTL and testbench

- Controller that sequences the circle-Hough accumulator BRAM for one frame.
- Per frame it clears the accumulator, then turns each edge pixel into four fixed-radius centre votes (left, right, up, down), each applied as a serialized read-modify-write.
- It tracks the running peak, and reports the best centre when the frame ends.
- Sits between the edge-threshold stage (pixel stream) and a single-port, read-first accumulator BRAM with 1-cycle read latency.

---
 rtl/hough_vote_ctrl_if.sv | 25 ++
 rtl/hough_vote_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hough_vote_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hough_vote_ctrl_if.sv
// Pixel-stream handshake and accumulator BRAM bus of the Hough vote controller.
// master = controller side, slave = pixel source plus BRAM side.
interface hough_vote_ctrl_if #(
  parameter int CNT_W  = 4,
  parameter int ADDR_W = 18
);
  logic              pix_valid;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;
  logic              pix_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_wdata;
  logic [CNT_W-1:0]  mem_rdata;

  modport master (
    input  pix_valid, pix_x, pix_y, mem_rdata,
    output pix_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output pix_valid, pix_x, pix_y, mem_rdata,
    input  pix_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/hough_vote_ctrl.sv
// Circle-Hough vote sequencer: clears the accumulator, applies four fixed-radius
// read-modify-write votes per edge pixel, and tracks the strongest centre.
module hough_vote_ctrl #(
  parameter int RADIUS   = 100,
  parameter int ACC_W    = 450,
  parameter int ACC_H    = 290,
  parameter int COL_BIAS = 95,
  parameter int ROW_BIAS = 95,
  parameter int CNT_W    = 4,
  parameter int ADDR_W   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 frame_end,
  hough_vote_ctrl_if.master    bus,
  output logic [9:0]           best_x,
  output logic [8:0]           best_y,
  output logic [CNT_W-1:0]     best_votes,
  output logic                 busy,
  output logic                 done
);

  localparam logic signed [11:0] RAD_S  = 12'(RADIUS);
  localparam logic signed [11:0] COL_LO = 12'(COL_BIAS);
  localparam logic signed [11:0] COL_HI = 12'(COL_BIAS + ACC_W);
  localparam logic signed [11:0] ROW_LO = 12'(ROW_BIAS);
  localparam logic signed [11:0] ROW_HI = 12'(ROW_BIAS + ACC_H);
  localparam logic [ADDR_W-1:0]  CLR_LAST = ADDR_W'(ACC_W * ACC_H - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, VOTE, CAND_RD, CAND_WR, DONE
  } state_t;

  typedef struct packed {
    logic              inw;
    logic [9:0]        bx;
    logic [8:0]        by;
    logic [ADDR_W-1:0] addr;
  } cand_t;

  function automatic cand_t cand_of(input logic [9:0] x, input logic [8:0] y,
                                    input logic [1:0] k);
    logic signed [11:0] cx;
    logic signed [11:0] cy;
    logic signed [11:0] col;
    logic signed [11:0] row;
    cand_t c;
    cx = signed'({2'b00, x});
    cy = signed'({3'b000, y});
    case (k)
      2'd0:    cx = cx - RAD_S;
      2'd1:    cx = cx + RAD_S;
      2'd2:    cy = cy - RAD_S;
      default: cy = cy + RAD_S;
    endcase
    col    = cx - COL_LO;
    row    = cy - ROW_LO;
    c.inw  = (cx >= COL_LO) && (cx < COL_HI) && (cy >= ROW_LO) && (cy < ROW_HI);
    c.bx   = cx[9:0];
    c.by   = cy[8:0];
    c.addr = ADDR_W'(col) + ADDR_W'(row) * ADDR_W'(ACC_W);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  logic [1:0]       k;
  logic [9:0]       px;
  logic [8:0]       py;
  logic             pending;
  cand_t            cur;
  cand_t            first_c;
  cand_t            next_c;
  logic [CNT_W-1:0] new_cnt;

  always_comb begin
    first_c = cand_of(bus.pix_x, bus.pix_y, 2'd0);
    next_c  = cand_of(px, py, k + 2'd1);
    new_cnt = sat_inc(bus.mem_rdata);
  end

  // Read data arrives in the write-back cycle itself, so the write data is combinational.
  assign bus.mem_wdata = (state == CAND_WR && cur.inw) ? new_cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= 2'd0;
      pending       <= 1'b0;
      bus.pix_ready <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      best_x        <= '0;
      best_y        <= '0;
      best_votes    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (start) begin
      state         <= CLEAR;
      pending       <= 1'b0;
      bus.pix_ready <= 1'b0;
      bus.mem_we    <= 1'b1;
      bus.mem_addr  <= '0;
      best_x        <= '0;
      best_y        <= '0;
      best_votes    <= '0;
      busy          <= 1'b1;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == CAND_RD || state == CAND_WR) && frame_end)
        pending <= 1'b1;
      case (state)
        CLEAR: begin
          if (bus.mem_addr == CLR_LAST) begin
            state         <= VOTE;
            bus.mem_we    <= 1'b0;
            bus.pix_ready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
          end
        end
        VOTE: begin
          if (bus.pix_valid) begin
            px            <= bus.pix_x;
            py            <= bus.pix_y;
            k             <= 2'd0;
            cur           <= first_c;
            bus.mem_addr  <= first_c.addr;
            bus.pix_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= CAND_RD;
            if (frame_end)
              pending <= 1'b1;
          end else if (frame_end || pending) begin
            state         <= DONE;
            done          <= 1'b1;
            pending       <= 1'b0;
            bus.pix_ready <= 1'b0;
          end
        end
        CAND_RD: begin
          bus.mem_we <= cur.inw;
          state      <= CAND_WR;
        end
        CAND_WR: begin
          bus.mem_we <= 1'b0;
          if (cur.inw && new_cnt > best_votes) begin
            best_votes <= new_cnt;
            best_x     <= cur.bx;
            best_y     <= cur.by;
          end
          if (k == 2'd3) begin
            state         <= VOTE;
            bus.pix_ready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            k            <= k + 2'd1;
            cur          <= next_c;
            bus.mem_addr <= next_c.addr;
            state        <= CAND_RD;
          end
        end
        DONE:    state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hough_vote_ctrl.sv
// Bench for hough_vote_ctrl on an 8x6 accumulator, radius 2, zero biases,
// with a read-first BRAM model and a queue of expected accumulator writes.
module tb_hough_vote_ctrl;
  localparam int RAD = 2;
  localparam int AW  = 8;
  localparam int AH  = 6;
  localparam int CW  = 4;
  localparam int ADW = 18;
  localparam int N   = AW * AH;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          frame_end = 1'b0;
  logic [9:0]    best_x;
  logic [8:0]    best_y;
  logic [CW-1:0] best_votes;
  logic          busy;
  logic          done;

  hough_vote_ctrl_if #(.CNT_W(CW), .ADDR_W(ADW)) bus ();

  hough_vote_ctrl #(
    .RADIUS(RAD), .ACC_W(AW), .ACC_H(AH), .COL_BIAS(0), .ROW_BIAS(0),
    .CNT_W(CW), .ADDR_W(ADW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_end(frame_end), .bus(bus),
    .best_x(best_x), .best_y(best_y), .best_votes(best_votes),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] mem [N];

  always @(posedge clk) begin
    bus.mem_rdata <= (int'(bus.mem_addr) < N) ? mem[int'(bus.mem_addr)] : '0;
    if (bus.mem_we && int'(bus.mem_addr) < N)
      mem[int'(bus.mem_addr)] <= bus.mem_wdata;
  end

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int x; int y; int bx; int by; int bv; } vec_t;

  wr_t exp_q[$];
  int  ref_acc[N];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(bus.mem_addr), -1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(bus.mem_addr), e.addr);
        chk("wr_data", int'(bus.mem_wdata), e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < N; i++) begin
      ref_acc[i] = 0;
      exp_q.push_back('{i, 0});
    end
  endtask

  // Expected writes for the first nk candidates of pixel (x,y).
  task automatic model_pixel(input int x, input int y, input int nk);
    int cx, cy, a;
    for (int kk = 0; kk < nk; kk++) begin
      cx = x; cy = y;
      case (kk)
        0: cx = x - RAD;
        1: cx = x + RAD;
        2: cy = y - RAD;
        default: cy = y + RAD;
      endcase
      if (cx >= 0 && cx < AW && cy >= 0 && cy < AH) begin
        a = cx + cy * AW;
        if (ref_acc[a] < SAT) ref_acc[a]++;
        exp_q.push_back('{a, ref_acc[a]});
      end
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    model_clear();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 100 && !bus.pix_ready; i++) tick();
    if (!bus.pix_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_pix(input int x, input int y, input bit fe, output int lat);
    wait_ready();
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 9'(y);
    frame_end     = fe;
    model_pixel(x, y, 4);
    tick();
    bus.pix_valid = 1'b0;
    frame_end     = 1'b0;
    lat = 0;
    while (!bus.pix_ready && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      if (done) n++;
      tick();
    end
  endtask

  task automatic chk_best(input string tag, input int bx, input int by, input int bv);
    chk({tag, "_best_x"}, int'(best_x), bx);
    chk({tag, "_best_y"}, int'(best_y), by);
    chk({tag, "_best_votes"}, int'(best_votes), bv);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[4];
    int   lat;
    int   nd;

    tbl[0] = '{4, 3, 2, 3, 1};
    tbl[1] = '{0, 0, 2, 3, 1};
    tbl[2] = '{2, 1, 4, 1, 2};
    tbl[3] = '{2, 5, 2, 3, 3};

    bus.pix_valid = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;

    repeat (3) tick();
    chk("rst_pix_ready", int'(bus.pix_ready), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_best("rst", 0, 0, 0);
    rst = 1'b0;

    // IDLE ignores pixels and frame_end
    bus.pix_valid = 1'b1;
    frame_end     = 1'b1;
    repeat (3) tick();
    bus.pix_valid = 1'b0;
    frame_end     = 1'b0;
    chk("idle_pix_ready", int'(bus.pix_ready), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);

    do_start();
    chk("clr_c1_addr", int'(bus.mem_addr), 0);
    chk("clr_c1_we", int'(bus.mem_we), 1);
    chk("clr_c1_busy", int'(busy), 1);
    repeat (47) tick();
    chk("clr_c48_ready", int'(bus.pix_ready), 0);
    tick();
    chk("clr_c49_ready", int'(bus.pix_ready), 1);
    chk("clr_c49_busy", int'(busy), 0);
    chk("clr_writes_drained", exp_q.size(), 0);

    for (int i = 0; i < 4; i++) begin
      send_pix(tbl[i].x, tbl[i].y, 1'b0, lat);
      chk("pix_latency", lat, 8);
      chk_best("tbl", tbl[i].bx, tbl[i].by, tbl[i].bv);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    count_done(6, nd);
    chk("frame_done_pulses", nd, 1);
    chk_best("after_done", 2, 3, 3);
    chk("frame_writes_drained", exp_q.size(), 0);

    // Saturation on a repeatedly hit centre
    do_start();
    for (int i = 0; i < 20; i++) send_pix(4, 3, 1'b0, lat);
    chk_best("sat", 2, 3, SAT);

    // frame_end together with a pixel: pixel completes, then done
    send_pix(4, 3, 1'b1, lat);
    chk("simul_latency", lat, 8);
    chk("simul_writes_before_done", exp_q.size(), 0);
    count_done(6, nd);
    chk("simul_done_pulses", nd, 1);
    chk_best("simul", 2, 3, SAT);

    // start in the middle of a pixel abandons the remaining candidates
    do_start();
    wait_ready();
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'd4;
    bus.pix_y     = 9'd3;
    model_pixel(4, 3, 1);
    tick();
    bus.pix_valid = 1'b0;
    tick();
    tick();
    chk_best("mid_before_start", 2, 3, 1);
    start = 1'b1;
    model_clear();
    tick();
    start = 1'b0;
    chk("mid_clr_addr", int'(bus.mem_addr), 0);
    chk("mid_clr_we", int'(bus.mem_we), 1);
    chk_best("mid_after_start", 0, 0, 0);
    wait_ready();
    chk("mid_writes_drained", exp_q.size(), 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    count_done(4, nd);
    chk("mid_done_pulses", nd, 1);
    chk_best("mid_final", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
